// File: rtl/multicycle_controller.sv
// Multicycle processor control FSM: sequences the shared ALU and unified memory
// across fetch/decode/execute/memory/writeback, gates writes on the ARM condition.
module multicycle_controller (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] op_i,
  input  logic [5:0] funct_i,
  input  logic [3:0] rd_i,
  input  logic [3:0] cond_i,
  input  logic [3:0] flags_i,
  input  logic       mem_ready_i,
  output logic [3:0] state_o,
  output logic       ir_write_o,
  output logic       pc_write_o,
  output logic       adr_src_o,
  output logic       mem_write_o,
  output logic       reg_write_o,
  output logic       alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic [1:0] result_src_o,
  output logic [1:0] imm_src_o,
  output logic [1:0] reg_src_o,
  output logic [1:0] alu_control_o,
  output logic [1:0] flag_write_o
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9
  } state_t;

  state_t     state_q, state_d;
  logic       cond_ex;
  logic       n_f, z_f, c_f, v_f;
  logic [3:0] cmd;
  logic       is_add, is_sub, is_cmp, is_and, is_orr, cmd_known, s_bit;
  logic [1:0] alu_dec_ctrl;
  logic [1:0] alu_dec_fw;
  logic       pc_dst;

  assign {n_f, z_f, c_f, v_f} = flags_i;
  assign cmd       = funct_i[4:1];
  assign pc_dst    = (rd_i == 4'b1111);
  assign state_o   = state_q;
  assign imm_src_o = op_i;
  assign reg_src_o = {op_i == 2'b01, op_i == 2'b10};

  // State register; reset returns to FETCH from any state, stalls included.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // ARM condition evaluation against the stored NZCV flags.
  always_comb begin
    cond_ex = 1'b0;
    case (cond_i)
      4'b0000: cond_ex = z_f;
      4'b0001: cond_ex = ~z_f;
      4'b0010: cond_ex = c_f;
      4'b0011: cond_ex = ~c_f;
      4'b0100: cond_ex = n_f;
      4'b0101: cond_ex = ~n_f;
      4'b0110: cond_ex = v_f;
      4'b0111: cond_ex = ~v_f;
      4'b1000: cond_ex = c_f & ~z_f;
      4'b1001: cond_ex = ~c_f | z_f;
      4'b1010: cond_ex = (n_f == v_f);
      4'b1011: cond_ex = (n_f != v_f);
      4'b1100: cond_ex = ~z_f & (n_f == v_f);
      4'b1101: cond_ex = z_f | (n_f != v_f);
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  // ALU operation and flag-write decode; CMP always updates flags.
  always_comb begin
    is_add    = (cmd == 4'b0100);
    is_sub    = (cmd == 4'b0010);
    is_cmp    = (cmd == 4'b1010);
    is_and    = (cmd == 4'b0000);
    is_orr    = (cmd == 4'b1100);
    cmd_known = is_add | is_sub | is_cmp | is_and | is_orr;
    s_bit     = funct_i[0] | is_cmp;
    alu_dec_ctrl = 2'b00;
    if (is_sub | is_cmp) alu_dec_ctrl = 2'b01;
    else if (is_and)     alu_dec_ctrl = 2'b10;
    else if (is_orr)     alu_dec_ctrl = 2'b11;
    alu_dec_fw[1] = s_bit & cond_ex & cmd_known;
    alu_dec_fw[0] = s_bit & cond_ex & (is_add | is_sub | is_cmp);
  end

  // Next-state selection.
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:    state_d = mem_ready_i ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op_i)
          2'b00:   state_d = funct_i[5] ? S_EXECI : S_EXECR;
          2'b01:   state_d = S_MEMADR;
          2'b10:   state_d = S_BRANCH;
          default: state_d = S_FETCH;
        endcase
      end
      S_MEMADR:   state_d = funct_i[0] ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  state_d = mem_ready_i ? S_MEMWB : S_MEMREAD;
      S_MEMWRITE: state_d = mem_ready_i ? S_FETCH : S_MEMWRITE;
      S_EXECR,
      S_EXECI:    state_d = is_cmp ? S_FETCH : S_ALUWB;
      default:    state_d = S_FETCH;
    endcase
  end

  // Moore outputs per state; reset forces FETCH selects with all strobes low.
  always_comb begin
    ir_write_o    = 1'b0;
    pc_write_o    = 1'b0;
    adr_src_o     = 1'b0;
    mem_write_o   = 1'b0;
    reg_write_o   = 1'b0;
    alu_src_a_o   = 1'b0;
    alu_src_b_o   = 2'b00;
    result_src_o  = 2'b00;
    alu_control_o = 2'b00;
    flag_write_o  = 2'b00;
    case (state_q)
      S_FETCH: begin
        alu_src_a_o  = 1'b1;
        alu_src_b_o  = 2'b10;
        result_src_o = 2'b10;
        ir_write_o   = mem_ready_i;
        pc_write_o   = mem_ready_i;
      end
      S_DECODE: begin
        alu_src_a_o  = 1'b1;
        alu_src_b_o  = 2'b10;
        result_src_o = 2'b10;
      end
      S_MEMADR:   alu_src_b_o = 2'b01;
      S_MEMREAD:  adr_src_o   = 1'b1;
      S_MEMWRITE: begin
        adr_src_o   = 1'b1;
        mem_write_o = cond_ex;
      end
      S_MEMWB: begin
        result_src_o = 2'b01;
        reg_write_o  = cond_ex;
        pc_write_o   = cond_ex & pc_dst;
      end
      S_EXECR: begin
        alu_control_o = alu_dec_ctrl;
        flag_write_o  = alu_dec_fw;
      end
      S_EXECI: begin
        alu_src_b_o   = 2'b01;
        alu_control_o = alu_dec_ctrl;
        flag_write_o  = alu_dec_fw;
      end
      S_ALUWB: begin
        reg_write_o = cond_ex & cmd_known;
        pc_write_o  = cond_ex & pc_dst;
      end
      S_BRANCH: begin
        alu_src_a_o  = 1'b1;
        alu_src_b_o  = 2'b01;
        result_src_o = 2'b10;
        pc_write_o   = cond_ex;
      end
      default: ;
    endcase
    if (rst_i) begin
      ir_write_o    = 1'b0;
      pc_write_o    = 1'b0;
      mem_write_o   = 1'b0;
      reg_write_o   = 1'b0;
      flag_write_o  = 2'b00;
      adr_src_o     = 1'b0;
      alu_src_a_o   = 1'b1;
      alu_src_b_o   = 2'b10;
      result_src_o  = 2'b10;
      alu_control_o = 2'b00;
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: per-cycle expectations are queued
// as stimulus is applied and compared at the following falling edge.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] rd, cond, flags;
  logic       mem_ready;
  logic [3:0] state;
  logic       ir_write, pc_write, adr_src, mem_write, reg_write, alu_src_a;
  logic [1:0] alu_src_b, result_src, imm_src, reg_src, alu_control, flag_write;

  localparam int SIG_STATE = 0, SIG_IRW = 1, SIG_PCW = 2, SIG_ADR = 3, SIG_MEMW = 4,
                 SIG_REGW = 5, SIG_SRCA = 6, SIG_SRCB = 7, SIG_RES = 8, SIG_ALU = 9,
                 SIG_FLAG = 10, SIG_IMM = 11, SIG_RSRC = 12;

  typedef struct {
    string tag;
    int    sig;
    int    val;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_err = 0;

  multicycle_controller dut (
    .clk_i(clk), .rst_i(rst), .op_i(op), .funct_i(funct), .rd_i(rd),
    .cond_i(cond), .flags_i(flags), .mem_ready_i(mem_ready),
    .state_o(state), .ir_write_o(ir_write), .pc_write_o(pc_write),
    .adr_src_o(adr_src), .mem_write_o(mem_write), .reg_write_o(reg_write),
    .alu_src_a_o(alu_src_a), .alu_src_b_o(alu_src_b), .result_src_o(result_src),
    .imm_src_o(imm_src), .reg_src_o(reg_src), .alu_control_o(alu_control),
    .flag_write_o(flag_write)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] get_sig(int s);
    case (s)
      SIG_STATE: return {28'd0, state};
      SIG_IRW:   return {31'd0, ir_write};
      SIG_PCW:   return {31'd0, pc_write};
      SIG_ADR:   return {31'd0, adr_src};
      SIG_MEMW:  return {31'd0, mem_write};
      SIG_REGW:  return {31'd0, reg_write};
      SIG_SRCA:  return {31'd0, alu_src_a};
      SIG_SRCB:  return {30'd0, alu_src_b};
      SIG_RES:   return {30'd0, result_src};
      SIG_ALU:   return {30'd0, alu_control};
      SIG_FLAG:  return {30'd0, flag_write};
      SIG_IMM:   return {30'd0, imm_src};
      default:   return {30'd0, reg_src};
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic expect_sig(input string tag, input int sig, input int val);
    exp_t e;
    e.tag = tag;
    e.sig = sig;
    e.val = val;
    sb.push_back(e);
  endtask

  // Compare everything queued for this cycle, then advance to just after the next edge.
  task automatic step();
    exp_t e;
    @(negedge clk);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check(e.tag, get_sig(e.sig), e.val[31:0]);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic st(input string tag, input int s);
    expect_sig(tag, SIG_STATE, s);
    step();
  endtask

  task automatic set_instr(input logic [1:0] o, input logic [5:0] f, input logic [3:0] r,
                           input logic [3:0] c, input logic [3:0] fl);
    op = o; funct = f; rd = r; cond = c; flags = fl;
  endtask

  task automatic fetch_decode(input string tag);
    expect_sig({tag, "_f_irw"}, SIG_IRW, 1);
    expect_sig({tag, "_f_pcw"}, SIG_PCW, 1);
    st({tag, "_f"}, 0);
    expect_sig({tag, "_d_srcb"}, SIG_SRCB, 2);
    st({tag, "_d"}, 1);
  endtask

  initial begin
    rst = 1'b1; mem_ready = 1'b1;
    set_instr(2'b11, 6'd0, 4'd0, 4'b1110, 4'd0);
    @(posedge clk); #1;
    // reset holds strobes low even with mem_ready high
    expect_sig("rst_irw", SIG_IRW, 0);
    expect_sig("rst_pcw", SIG_PCW, 0);
    expect_sig("rst_srcb", SIG_SRCB, 2);
    expect_sig("rst_res", SIG_RES, 2);
    st("rst_state", 0);

    rst = 1'b0; mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      expect_sig("wait_pcw", SIG_PCW, 0);
      expect_sig("wait_irw", SIG_IRW, 0);
      st("wait_state", 0);
    end
    mem_ready = 1'b1;
    expect_sig("imm_src_nop", SIG_IMM, 3);
    fetch_decode("nop");

    // ADD register
    set_instr(2'b00, 6'b001001, 4'd3, 4'b1110, 4'd0);
    fetch_decode("add");
    expect_sig("add_alu", SIG_ALU, 0);
    expect_sig("add_flag", SIG_FLAG, 3);
    expect_sig("add_srcb", SIG_SRCB, 0);
    st("add_execr", 6);
    expect_sig("add_regw", SIG_REGW, 1);
    expect_sig("add_pcw", SIG_PCW, 0);
    st("add_aluwb", 8);

    // Load to PC, no stall
    set_instr(2'b01, 6'b000001, 4'hF, 4'b1110, 4'd0);
    expect_sig("ld_rsrc", SIG_RSRC, 2);
    fetch_decode("ld");
    expect_sig("ld_srcb", SIG_SRCB, 1);
    st("ld_memadr", 2);
    expect_sig("ld_adr", SIG_ADR, 1);
    st("ld_memread", 3);
    expect_sig("ld_res", SIG_RES, 1);
    expect_sig("ld_regw", SIG_REGW, 1);
    expect_sig("ld_pcw", SIG_PCW, 1);
    st("ld_memwb", 4);

    // Load with two MEMREAD wait cycles
    fetch_decode("ldw");
    st("ldw_memadr", 2);
    mem_ready = 1'b0;
    st("ldw_wait1", 3);
    st("ldw_wait2", 3);
    mem_ready = 1'b1;
    st("ldw_memread", 3);
    st("ldw_memwb", 4);

    // Store with EQ false
    set_instr(2'b01, 6'b000000, 4'd2, 4'b0000, 4'b0000);
    fetch_decode("stq");
    st("stq_memadr", 2);
    expect_sig("stq_memw", SIG_MEMW, 0);
    expect_sig("stq_adr", SIG_ADR, 1);
    st("stq_memwrite", 5);

    // Branch NE taken
    set_instr(2'b10, 6'd0, 4'd0, 4'b0001, 4'b0000);
    expect_sig("stq_done", SIG_STATE, 0);
    fetch_decode("bne");
    expect_sig("bne_pcw", SIG_PCW, 1);
    st("bne_branch", 9);

    // Branch NE not taken
    flags = 4'b0100;
    fetch_decode("beq");
    expect_sig("beq_pcw", SIG_PCW, 0);
    st("beq_branch", 9);

    // CMP skips writeback
    set_instr(2'b00, 6'b010101, 4'd5, 4'b1110, 4'd0);
    fetch_decode("cmp");
    expect_sig("cmp_alu", SIG_ALU, 1);
    expect_sig("cmp_flag", SIG_FLAG, 3);
    st("cmp_execr", 6);
    expect_sig("cmp_regw", SIG_REGW, 0);
    expect_sig("cmp_back", SIG_STATE, 0);

    // Unknown cmd via EXECI: no flags, no register write
    set_instr(2'b00, 6'b101111, 4'd4, 4'b1110, 4'd0);
    fetch_decode("unk");
    expect_sig("unk_alu", SIG_ALU, 0);
    expect_sig("unk_flag", SIG_FLAG, 0);
    expect_sig("unk_srcb", SIG_SRCB, 1);
    st("unk_execi", 7);
    expect_sig("unk_regw", SIG_REGW, 0);
    st("unk_aluwb", 8);

    // Reset during a MEMWRITE stall
    set_instr(2'b01, 6'b000000, 4'd1, 4'b1110, 4'd0);
    fetch_decode("rsw");
    st("rsw_memadr", 2);
    mem_ready = 1'b0;
    expect_sig("rsw_memw", SIG_MEMW, 1);
    st("rsw_stall", 5);
    rst = 1'b1;
    expect_sig("rsw_rst_memw", SIG_MEMW, 0);
    st("rsw_rst_state", 5);
    rst = 1'b0;
    expect_sig("rsw_after_memw", SIG_MEMW, 0);
    st("rsw_after_state", 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
